// File: rtl/serial_pkg.sv
// Shared types for the serial pattern-detector chain front end.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam logic SER_IDLE_BIT = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out,
// with a single holding register so consecutive words stream without a gap.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_active,
  output logic             done
);

  localparam int            CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
  localparam int            OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

  ser_state_t       state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic             accept;
  logic             last_bit;

  // hold_full is a register, so load_ready never depends on load_valid.
  assign load_ready = ~hold_full;
  assign accept     = load_valid & ~hold_full;
  assign last_bit   = (cnt == LAST);

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sr    <= data_in;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            sr  <= shift1(sr);
            cnt <= cnt + 1'b1;
            if (accept) begin
              hold      <= data_in;
              hold_full <= 1'b1;
            end
          end else if (hold_full) begin
            // hold drains first; accept cannot fire here since load_ready is low
            sr        <= hold;
            hold_full <= 1'b0;
            cnt       <= '0;
          end else if (accept) begin
            sr  <= data_in;
            cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ser_active = (state == SHIFT);
  assign ser_out    = ser_active ? sr[OUT_IDX] : SER_IDLE_BIT;
  assign done       = ser_active & last_bit;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed + random bench for bit_serializer; MSB-first and LSB-first instances share stimulus.
module tb_bit_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         rdy_m, out_m, act_m, done_m;
  logic         rdy_l, out_l, act_l, done_l;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: queue of bits still to be sent, current bit at the front.
  bit qm[$];
  bit ql[$];

  logic [31:0] cap_m, cap_l;
  int          act_cnt, done_cnt;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(rdy_m), .ser_out(out_m), .ser_active(act_m), .done(done_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(rdy_l), .ser_out(out_l), .ser_active(act_l), .done(done_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic v, input logic [W-1:0] d, input logic r);
    logic acc;
    int   n;
    load_valid = v;
    data_in    = d;
    rst        = r;
    acc = v && (qm.size() <= W) && !r;
    @(posedge clk);
    if (r) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (acc)
        for (int i = 0; i < W; i++) begin
          qm.push_back(d[W-1-i]);
          ql.push_back(d[i]);
        end
    end
    @(negedge clk);
    n = qm.size();
    if (act_m) begin
      cap_m = {cap_m[30:0], out_m};
      cap_l = {cap_l[30:0], out_l};
      act_cnt++;
    end
    if (done_m) done_cnt++;
    check("ser_out_msb", {31'd0, out_m},  {31'd0, (n > 0) ? qm[0] : 1'b0});
    check("ser_out_lsb", {31'd0, out_l},  {31'd0, (n > 0) ? ql[0] : 1'b0});
    check("ser_active",  {31'd0, act_m},  {31'd0, n > 0});
    check("done",        {31'd0, done_m}, {31'd0, (n == 1) || (n == W + 1)});
    check("load_ready",  {31'd0, rdy_m},  {31'd0, n <= W});
    check("done_lsb",    {31'd0, done_l}, {31'd0, (n == 1) || (n == W + 1)});
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic clear_stats();
    cap_m    = '0;
    cap_l    = '0;
    act_cnt  = 0;
    done_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; data_in = '0;
    clear_stats();

    // Reset state
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'hA5, 1'b1);
    idle(2);

    // Single word 0xB0
    clear_stats();
    tick(1'b1, 8'hB0, 1'b0);
    idle(10);
    check("single_stream", cap_m[7:0], 8'hB0);
    check("single_active", act_cnt, 8);
    check("single_done",   done_cnt, 1);

    // Back-to-back 0xB0 then 0x5A via hold
    clear_stats();
    tick(1'b1, 8'hB0, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h5A, 1'b0);
    idle(18);
    check("b2b_stream", cap_m[15:0], 16'hB05A);
    check("b2b_active", act_cnt, 16);
    check("b2b_done",   done_cnt, 2);

    // Bypass: second word offered only on the last-bit edge
    clear_stats();
    tick(1'b1, 8'hFF, 1'b0);
    idle(7);
    tick(1'b1, 8'h00, 1'b0);
    idle(10);
    check("bypass_stream", cap_m[15:0], 16'hFF00);
    check("bypass_active", act_cnt, 16);

    // LSB-first ordering of 0x0D shows up as 1,0,1,1,0,0,0,0
    clear_stats();
    tick(1'b1, 8'h0D, 1'b0);
    idle(10);
    check("lsb_stream", cap_l[7:0], 8'hB0);

    // Reset mid-word with hold full; valid high on the reset edge
    clear_stats();
    tick(1'b1, 8'hB0, 1'b0);
    tick(1'b1, 8'h5A, 1'b0);
    idle(2);
    tick(1'b1, 8'hC3, 1'b1);
    check("rst_active", {31'd0, act_m}, 32'd0);
    check("rst_ready",  {31'd0, rdy_m}, 32'd1);
    act_cnt = 0;
    idle(20);
    check("rst_no_bits", act_cnt, 0);

    // load_valid held high while hold is full
    clear_stats();
    tick(1'b1, 8'h81, 1'b0);
    tick(1'b1, 8'h42, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 8'hE7, 1'b0);
    idle(20);
    check("hold_words", done_cnt, 2);
    check("hold_stream", cap_m[15:0], 16'h8142);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++)
      tick($urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 60) == 0);
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the serial pattern-detector chain (11 / 101 / 1011 Moore detector). Accepts WIDTH-bit words over a valid/ready handshake and drives one bit per clock on `ser_out`, which connects directly to the detector's serial input. A one-word holding register keeps back-to-back words gapless. When the block has nothing to send, it drives 0.

## Interface
- `WIDTH`, default 8: word width in bits, must be ≥ 2.
- `MSB_FIRST`, default 1: 1 = bit WIDTH-1 first; 0 = bit 0 first.

Ports:
- `clk`  in  1  : single clock; all logic on the rising edge.
- `rst`  in  1  : synchronous, active-high reset.
- `data_in`  in  WIDTH  : word to serialize.
- `load_valid`  in  1  : `data_in` is valid.
- `load_ready`  out  1  : block can accept a word this cycle.
- `ser_out`  out  1  : serial bit to the detector.
- `ser_active`  out  1  : `ser_out` carries a data bit this cycle.
- `done`  out  1  : this cycle carries the last bit of a word.

## Operation
- A word is accepted on any rising edge where `load_valid && load_ready` is true.
- Storage:
  - shift register `sr` (WIDTH bits);
  - bit counter `cnt`, $clog2(WIDTH) bits, range 0..WIDTH-1;
  - holding register `hold` with flag `hold_full`.
- FSM states:
  - IDLE: `sr` empty, `hold` empty.
  - SHIFT: `sr` is presenting bits.
- IDLE:
  - On accept, the word loads into `sr`, `cnt`=0, next state SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, not on the last bit (`cnt` < WIDTH-1):
  - Shift one position toward the output end and increment `cnt`.
  - An accept writes `hold` and sets `hold_full`.
- SHIFT, last-bit edge (`cnt` == WIDTH-1), in priority order:
  - If `hold_full`: `hold` moves to `sr`, `hold_full` clears, `cnt`=0, stay in SHIFT.
  - Else if an accept occurs: bypass, the word loads straight into `sr`, `cnt`=0, stay in SHIFT.
  - Else: next state IDLE.
- `load_ready` = !`hold_full`. It is a registered flag; there is no combinational path from `load_valid`.
- A word written to `hold` on the same last-bit edge on which `hold` drains cannot happen, because `load_ready` was low on that edge.
- `ser_out`:
  - In SHIFT, the output-end bit of `sr` (MSB when MSB_FIRST=1, else LSB).
  - In IDLE, forced to 0.
- `ser_active` = (state == SHIFT).
- `done` = SHIFT && `cnt` == WIDTH-1.
- `data_in` is ignored when not accepted. Contents of `sr` and `hold` are don't-care while not in use.

## Timing
- Reset values, effective the cycle after the reset edge:
  - state IDLE, `hold_full`=0, `cnt`=0;
  - `ser_out`=0, `ser_active`=0, `done`=0, `load_ready`=1.
- Latency: a word accepted at edge k presents its first bit in the cycle after edge k. Its last bit appears in the cycle after edge k+WIDTH-1.
- Throughput: one bit per clock with no idle gap between consecutive words, provided the next word is accepted no later than the last-bit edge of the current one.
- `load_ready` drops the cycle after `hold` is written. It rises again the cycle after the last-bit edge that drains `hold`.
- `rst` mid-word: both words are discarded, and all outputs return to their reset values the cycle after the edge.
- If `rst` and `load_valid` are high on the same edge, reset wins and the word is not accepted.

## Structure
- Shared package `serial_pkg` holds:
  - state enum `ser_state_t` {IDLE, SHIFT};
  - constant `SER_IDLE_BIT` = 1'b0.
- Single module; no sub-module. The holding register is a plain register plus its flag and does not justify a separate block.

## Test plan
- Reset, then `data_in`=8'hB0 accepted at edge 0 with MSB_FIRST=1:
  - `ser_out` = 1,0,1,1,0,0,0,0 over cycles 1-8;
  - `done` high only in cycle 8;
  - `ser_active` high in cycles 1-8, `ser_out`=0 from cycle 9.
- Back-to-back 8'hB0 then 8'h5A, with the second accepted at edge 2:
  - 16 contiguous bits 10110000 01011010;
  - `load_ready` low in cycles 3-8;
  - `done` high in cycles 8 and 16.
- Bypass path: 8'hFF, then 8'h00 offered only at the last-bit edge of the first word:
  - `ser_out` = eight 1s followed by eight 0s, gapless, `ser_active` continuous.
- MSB_FIRST=0 with 8'h0D: `ser_out` = 1,0,1,1,0,0,0,0.
- `rst` asserted at the edge after bit 3 of 8'hB0, with `hold` full:
  - next cycle `ser_out`=0, `ser_active`=0, `load_ready`=1;
  - no bits from either word appear afterwards.
- `load_valid` held high with `hold` full for 5 cycles:
  - no extra word is accepted;
  - exactly two words are serialized.
